// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the PicoBlaze interrupt controller: default port
// addresses, source count and the 2-bit FSM state encodings.
package irq_ctrl_pkg;

    localparam int         NUM_SRC          = 8;
    localparam logic [7:0] DEF_PORT_STATUS  = 8'h10;
    localparam logic [7:0] DEF_PORT_MASK    = 8'h11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ASSERT  = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

endpackage

// File: rtl/irq_ctrl_sync_edge.sv
// Per-source synchronizer chain followed by a rising-edge detector.
// rise is high for exactly one clock after the synchronized level goes 0->1.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic src,
    output logic rise
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes a shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], src};
            prev  <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// PicoBlaze interrupt controller: 8 edge-triggered sources, pending/mask
// registers on the I/O bus and an IDLE/ASSERT/SERVICE handshake FSM.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [7:0] PORT_STATUS = DEF_PORT_STATUS,
    parameter logic [7:0] PORT_MASK   = DEF_PORT_MASK,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq_src,
    input  logic [7:0] port_id,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    state_t             state;
    logic               wr_status;
    logic               wr_mask;
    logic               unused_read_strobe;

    // Reads have no side effects, so the INPUT qualifier is not needed.
    assign unused_read_strobe = read_strobe;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
            .clk  (clk),
            .rst  (rst),
            .src  (irq_src[i]),
            .rise (rise[i])
        );
    end

    assign wr_status = write_strobe && (port_id == PORT_STATUS);
    assign wr_mask   = write_strobe && (port_id == PORT_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            mask    <= '0;
            in_port <= '0;
        end else begin
            // A new edge overrides a same-cycle write-1-to-clear.
            pending <= (pending & ~(wr_status ? out_port : 8'h00)) | rise;
            if (wr_mask)
                mask <= out_port;
            if (port_id == PORT_STATUS)
                in_port <= pending;
            else if (port_id == PORT_MASK)
                in_port <= mask;
            else
                in_port <= 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            interrupt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|(pending & mask)) begin
                        state     <= ST_ASSERT;
                        interrupt <= 1'b1;
                    end else begin
                        interrupt <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    // Held until acknowledged, even if the masked pending clears.
                    if (interrupt_ack) begin
                        state     <= ST_SERVICE;
                        interrupt <= 1'b0;
                    end else begin
                        interrupt <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    interrupt <= 1'b0;
                    if (wr_status)
                        state <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    interrupt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expectations are queued as stimulus is applied
// and popped when the corresponding DUT value is sampled.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_src = 8'h00;
    logic [7:0] port_id = 8'h22;
    logic       write_strobe = 1'b0;
    logic       read_strobe = 1'b0;
    logic [7:0] out_port = 8'h00;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack = 1'b0;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    irq_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .irq_src       (irq_src),
        .port_id       (port_id),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .out_port      (out_port),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [7:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        total_cnt++;
        if (sb_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL scoreboard_empty: observed %h required none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) pass_cnt++;
            else begin
                fail_cnt++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic write_port(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0;
        port_id      = 8'h22;
    endtask

    task automatic read_port(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        port_id     = addr;
        read_strobe = 1'b1;
        expect_val(tag, exp);
        tick(1);
        read_strobe = 1'b0;
        check(in_port);
        port_id = 8'h22;
    endtask

    initial begin
        // Reset state
        expect_val("rst_in_port", 8'h00);
        expect_val("rst_interrupt", 8'h00);
        tick(2);
        check(in_port);
        check({7'b0, interrupt});
        rst = 1'b0;
        expect_val("rst_pending", 8'h00);
        expect_val("rst_state", 8'(ST_IDLE));
        tick(1);
        check(dut.pending);
        check(8'(dut.state));

        // Basic latency, ack and clear on source 0
        write_port(DEF_PORT_MASK, 8'h01);
        irq_src[0] = 1'b1;
        expect_val("t1_pending_clk2", 8'h00);
        tick(2);
        check(dut.pending);
        expect_val("t1_pending_clk3", 8'h01);
        expect_val("t1_int_clk3", 8'h00);
        tick(1);
        check(dut.pending);
        check({7'b0, interrupt});
        expect_val("t1_int_clk4", 8'h01);
        tick(1);
        check({7'b0, interrupt});
        expect_val("t1_int_hold", 8'h01);
        tick(1);
        check({7'b0, interrupt});
        interrupt_ack = 1'b1;
        expect_val("t1_int_ack", 8'h00);
        expect_val("t1_state_service", 8'(ST_SERVICE));
        tick(1);
        interrupt_ack = 1'b0;
        check({7'b0, interrupt});
        check(8'(dut.state));
        irq_src[0] = 1'b0;
        expect_val("t1_pending_clr", 8'h00);
        expect_val("t1_state_idle", 8'(ST_IDLE));
        write_port(DEF_PORT_STATUS, 8'h01);
        check(dut.pending);
        check(8'(dut.state));

        // Masked capture, then unmask
        write_port(DEF_PORT_MASK, 8'h00);
        irq_src[3] = 1'b1;
        tick(2);
        irq_src[3] = 1'b0;
        expect_val("t2_pending_masked", 8'h08);
        expect_val("t2_int_masked", 8'h00);
        tick(4);
        check(dut.pending);
        check({7'b0, interrupt});
        write_port(DEF_PORT_MASK, 8'h08);
        expect_val("t2_int_unmask", 8'h01);
        tick(1);
        check({7'b0, interrupt});
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        expect_val("t2_pending_clr", 8'h00);
        write_port(DEF_PORT_STATUS, 8'h08);
        check(dut.pending);

        // Set wins over same-cycle clear, then back-to-back re-assert
        write_port(DEF_PORT_MASK, 8'h04);
        irq_src[2] = 1'b1;
        expect_val("t3_int_first", 8'h01);
        tick(4);
        check({7'b0, interrupt});
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        irq_src[2] = 1'b0;
        tick(4);
        irq_src[2] = 1'b1;
        tick(2);
        expect_val("t3_pending_setwins", 8'h04);
        expect_val("t3_state_idle", 8'(ST_IDLE));
        expect_val("t3_int_idle", 8'h00);
        write_port(DEF_PORT_STATUS, 8'h04);
        check(dut.pending);
        check(8'(dut.state));
        check({7'b0, interrupt});
        expect_val("t3_int_reassert", 8'h01);
        tick(1);
        check({7'b0, interrupt});
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        write_port(DEF_PORT_STATUS, 8'h04);
        irq_src[2] = 1'b0;

        // Register readback
        write_port(DEF_PORT_MASK, 8'h00);
        tick(3);
        irq_src = 8'hA5;
        expect_val("t4_pending", 8'hA5);
        tick(3);
        check(dut.pending);
        write_port(DEF_PORT_MASK, 8'h3C);
        read_port("t4_read_status", 8'h10, 8'hA5);
        read_port("t4_read_mask", 8'h11, 8'h3C);
        read_port("t4_read_other", 8'h22, 8'h00);
        read_port("t4_read_status_again", 8'h10, 8'hA5);
        expect_val("t4_int_asserted", 8'h01);
        check({7'b0, interrupt});

        // Reset in ASSERT with all sources high through release
        irq_src = 8'hFF;
        rst = 1'b1;
        #1;
        expect_val("t5_int_async", 8'h00);
        expect_val("t5_pending_async", 8'h00);
        expect_val("t5_mask_async", 8'h00);
        check({7'b0, interrupt});
        check(dut.pending);
        check(dut.mask);
        tick(2);
        rst = 1'b0;
        expect_val("t5_pending_clk2", 8'h00);
        tick(2);
        check(dut.pending);
        expect_val("t5_pending_clk3", 8'hFF);
        expect_val("t5_int_masked", 8'h00);
        tick(1);
        check(dut.pending);
        check({7'b0, interrupt});

        // New edges during SERVICE stay pending until the ISR clears
        write_port(DEF_PORT_STATUS, 8'hFF);
        irq_src = 8'h00;
        write_port(DEF_PORT_MASK, 8'hFF);
        tick(3);
        irq_src[0] = 1'b1;
        expect_val("t6_int_first", 8'h01);
        tick(4);
        check({7'b0, interrupt});
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        irq_src[5] = 1'b1;
        tick(1);
        irq_src[6] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            expect_val("t6_int_service", 8'h00);
            tick(1);
            check({7'b0, interrupt});
        end
        expect_val("t6_pending_service", 8'h61);
        check(dut.pending);
        expect_val("t6_int_after_clear", 8'h00);
        write_port(DEF_PORT_STATUS, 8'h01);
        check({7'b0, interrupt});
        expect_val("t6_int_next", 8'h01);
        tick(1);
        check({7'b0, interrupt});

        total_cnt++;
        assert (sb_q.size() == 0) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL scoreboard_leftover: observed %0d required 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
